// File: rtl/wb_select_pipe_if.sv
// Bus bundle for the write-back select stage: issue fields, ALU result,
// hazard query inputs and the register-file write port.
interface wb_select_pipe_if #(
   parameter int DATA_W    = 32,
   parameter int IMM_W     = 20,
   parameter int RF_ADDR_W = 5,
   parameter int CNT_W     = 16
);
   logic                 stall;
   logic                 in_valid;
   logic [6:0]           OPCODE;
   logic [IMM_W-1:0]     INP;
   logic [RF_ADDR_W-1:0] RD_ADDR;
   logic [DATA_W-1:0]    ALU_OUT;
   logic [RF_ADDR_W-1:0] rs1_addr;
   logic [RF_ADDR_W-1:0] rs2_addr;

   logic                 wr_en_RF;
   logic [RF_ADDR_W-1:0] wr_addr_RF;
   logic [DATA_W-1:0]    Data_In_RF;
   logic                 hazard;
   logic [CNT_W-1:0]     wb_count;

   modport master (
      output stall, in_valid, OPCODE, INP, RD_ADDR, ALU_OUT, rs1_addr, rs2_addr,
      input  wr_en_RF, wr_addr_RF, Data_In_RF, hazard, wb_count
   );

   modport slave (
      input  stall, in_valid, OPCODE, INP, RD_ADDR, ALU_OUT, rs1_addr, rs2_addr,
      output wr_en_RF, wr_addr_RF, Data_In_RF, hazard, wb_count
   );
endinterface

// File: rtl/wb_select_pipe.sv
// Write-back select stage: aligns issued instructions over LAT stages, picks
// the register-file write data, flags RAW hazards and counts committed writes.
module wb_select_pipe #(
   parameter int DATA_W    = 32,
   parameter int IMM_W     = 20,
   parameter int RF_ADDR_W = 5,
   parameter int LAT       = 2,
   parameter int SIGN_EXT  = 0,
   parameter int CNT_W     = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   wb_select_pipe_if.slave bus
);

   localparam logic [6:0] OP_LI  = 7'b1111111;
   localparam logic [6:0] OP_ALU = 7'b0110011;
   localparam logic [6:0] OP_NOP = 7'b0000000;

   typedef struct packed {
      logic                 valid;
      logic [6:0]           opcode;
      logic [IMM_W-1:0]     imm;
      logic [RF_ADDR_W-1:0] rd;
   } stage_t;

   stage_t              stage_q [LAT];
   stage_t              stage_d [LAT];
   logic [DATA_W-1:0]   hold_q;
   logic [DATA_W-1:0]   hold_d;
   logic [CNT_W-1:0]    count_q;
   logic [CNT_W-1:0]    count_d;

   stage_t              fin;
   logic [DATA_W-1:0]   imm_ext;
   logic [DATA_W-1:0]   sel_data;
   logic                do_write;
   logic                wr_en;
   logic                hazard_c;

   // NOTE: every variable assigned in an always_comb gets a default first so
   // no path leaves it unassigned, which would infer a latch.
   always_comb begin
      stage_d[0] = '{valid:  bus.in_valid,
                     opcode: bus.OPCODE,
                     imm:    bus.INP,
                     rd:     bus.RD_ADDR};
      for (int k = 1; k < LAT; k++) begin
         stage_d[k] = stage_q[k-1];
      end
   end

   assign fin = stage_q[LAT-1];

   always_comb begin
      imm_ext = DATA_W'(fin.imm);
      if (SIGN_EXT != 0) begin
         imm_ext = DATA_W'($signed(fin.imm));
      end
   end

   // An invalid final stage decodes exactly like NO_OPERATION.
   always_comb begin
      sel_data = hold_q;
      do_write = 1'b0;
      if (fin.valid) begin
         case (fin.opcode)
            OP_LI: begin
               sel_data = imm_ext;
               do_write = 1'b1;
            end
            OP_ALU: begin
               sel_data = bus.ALU_OUT;
               do_write = 1'b1;
            end
            OP_NOP: begin
               sel_data = hold_q;
            end
            default: begin
               sel_data = bus.ALU_OUT;
            end
         endcase
      end
   end

   // Gating with stall keeps a frozen final stage from writing twice.
   assign wr_en = do_write && !bus.stall && (fin.rd != '0);

   always_comb begin
      hazard_c = 1'b0;
      for (int k = 0; k < LAT; k++) begin
         if (stage_q[k].valid &&
             (stage_q[k].opcode == OP_LI || stage_q[k].opcode == OP_ALU) &&
             (stage_q[k].rd != '0) &&
             (stage_q[k].rd == bus.rs1_addr || stage_q[k].rd == bus.rs2_addr)) begin
            hazard_c = 1'b1;
         end
      end
   end

   always_comb begin
      hold_d  = hold_q;
      count_d = count_q;
      if (wr_en) begin
         hold_d = sel_data;
         if (count_q != '1) begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples the pre-edge value of its neighbours.
   // NOTE: the stage array is only LAT entries of flops, not a RAM, and its
   // valid bits must clear on reset, so each entry is reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LAT; k++) begin
            stage_q[k] <= '0;
         end
         hold_q  <= '0;
         count_q <= '0;
      end else if (!bus.stall) begin
         for (int k = 0; k < LAT; k++) begin
            stage_q[k] <= stage_d[k];
         end
         hold_q  <= hold_d;
         count_q <= count_d;
      end
   end

   assign bus.wr_en_RF   = wr_en;
   assign bus.wr_addr_RF = fin.rd;
   assign bus.Data_In_RF = sel_data;
   assign bus.hazard     = hazard_c;
   assign bus.wb_count   = count_q;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Directed bench for wb_select_pipe: instance A (LAT=2, zero-extend, 16-bit
// count) and instance B (LAT=3, sign-extend, 3-bit count) share one stimulus.
module tb_wb_select_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        run = 1'b0;
   logic        stall = 1'b0;
   logic        in_valid = 1'b0;
   logic [6:0]  opcode = '0;
   logic [19:0] inp = '0;
   logic [4:0]  rd_addr = '0;
   logic [31:0] alu_out = '0;
   logic [4:0]  rs1 = '0;
   logic [4:0]  rs2 = '0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   wb_select_pipe_if #(.DATA_W(32), .IMM_W(20), .RF_ADDR_W(5), .CNT_W(16)) bus_a ();
   wb_select_pipe_if #(.DATA_W(32), .IMM_W(20), .RF_ADDR_W(5), .CNT_W(3))  bus_b ();

   assign bus_a.stall = stall;     assign bus_b.stall = stall;
   assign bus_a.in_valid = in_valid; assign bus_b.in_valid = in_valid;
   assign bus_a.OPCODE = opcode;   assign bus_b.OPCODE = opcode;
   assign bus_a.INP = inp;         assign bus_b.INP = inp;
   assign bus_a.RD_ADDR = rd_addr; assign bus_b.RD_ADDR = rd_addr;
   assign bus_a.ALU_OUT = alu_out; assign bus_b.ALU_OUT = alu_out;
   assign bus_a.rs1_addr = rs1;    assign bus_b.rs1_addr = rs1;
   assign bus_a.rs2_addr = rs2;    assign bus_b.rs2_addr = rs2;

   wb_select_pipe #(.DATA_W(32), .IMM_W(20), .RF_ADDR_W(5), .LAT(2),
                    .SIGN_EXT(0), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a.slave));

   wb_select_pipe #(.DATA_W(32), .IMM_W(20), .RF_ADDR_W(5), .LAT(3),
                    .SIGN_EXT(1), .CNT_W(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a history of every non-stalled issue slot since reset. The
   // instruction at write-back is the one issued LAT advances ago; the
   // in-flight set is the last LAT issue slots.
   typedef struct {
      logic        v;
      logic [6:0]  op;
      logic [19:0] imm;
      logic [4:0]  rd;
   } ins_t;

   ins_t        hist [2][0:4095];
   int          n    [2] = '{0, 0};
   logic [31:0] hold [2] = '{0, 0};
   int          cnt  [2] = '{0, 0};

   function automatic int lat_of(int i);
      return (i == 0) ? 2 : 3;
   endfunction

   function automatic int cmax_of(int i);
      return (i == 0) ? 65535 : 7;
   endfunction

   function automatic ins_t fin_of(int i);
      ins_t e = '{v: 1'b0, op: 7'd0, imm: 20'd0, rd: 5'd0};
      if (n[i] >= lat_of(i)) e = hist[i][n[i] - lat_of(i)];
      return e;
   endfunction

   function automatic logic [31:0] exp_data(int i);
      ins_t e = fin_of(i);
      if (!e.v || e.op == 7'h00) return hold[i];
      if (e.op == 7'h7F) begin
         if (i == 1 && e.imm[19]) return {12'hFFF, e.imm};
         return {12'h000, e.imm};
      end
      return alu_out;
   endfunction

   function automatic logic exp_wr(int i);
      ins_t e = fin_of(i);
      return e.v && (e.op == 7'h7F || e.op == 7'h33) && !stall && e.rd != 5'd0;
   endfunction

   function automatic logic exp_haz(int i);
      logic h = 1'b0;
      for (int k = n[i] - lat_of(i); k < n[i]; k++) begin
         if (k >= 0) begin
            if (hist[i][k].v && (hist[i][k].op == 7'h7F || hist[i][k].op == 7'h33) &&
                hist[i][k].rd != 5'd0 && (hist[i][k].rd == rs1 || hist[i][k].rd == rs2))
               h = 1'b1;
         end
      end
      return h;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            n[i]    <= 0;
            hold[i] <= '0;
            cnt[i]  <= 0;
         end else if (!stall) begin
            if (exp_wr(i)) begin
               hold[i] <= exp_data(i);
               cnt[i]  <= (cnt[i] == cmax_of(i)) ? cnt[i] : cnt[i] + 1;
            end
            hist[i][n[i]] <= '{v: in_valid, op: opcode, imm: inp, rd: rd_addr};
            n[i] <= n[i] + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (run) begin
         check("a_wr_en",  32'(bus_a.wr_en_RF),   32'(exp_wr(0)));
         check("a_wr_addr",32'(bus_a.wr_addr_RF), 32'(fin_of(0).rd));
         check("a_data",   bus_a.Data_In_RF,      exp_data(0));
         check("a_hazard", 32'(bus_a.hazard),     32'(exp_haz(0)));
         check("a_count",  32'(bus_a.wb_count),   32'(cnt[0]));
         check("b_wr_en",  32'(bus_b.wr_en_RF),   32'(exp_wr(1)));
         check("b_wr_addr",32'(bus_b.wr_addr_RF), 32'(fin_of(1).rd));
         check("b_data",   bus_b.Data_In_RF,      exp_data(1));
         check("b_hazard", 32'(bus_b.hazard),     32'(exp_haz(1)));
         check("b_count",  32'(bus_b.wb_count),   32'(cnt[1]));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [6:0] op, input logic [19:0] imm, input logic [4:0] rd);
      in_valid = 1'b1;
      opcode   = op;
      inp      = imm;
      rd_addr  = rd;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      opcode   = '0;
      inp      = '0;
      rd_addr  = '0;
   endtask

   initial begin
      #2 rst_n = 1'b0;
      run = 1'b1;
      @(negedge clk);
      check("rst_a_wr_en", 32'(bus_a.wr_en_RF), 32'd0);
      check("rst_a_addr",  32'(bus_a.wr_addr_RF), 32'd0);
      check("rst_a_data",  bus_a.Data_In_RF, 32'd0);
      check("rst_a_haz",   32'(bus_a.hazard), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();

      // Load-immediate, zero- and sign-extended
      issue(7'h7F, 20'hABCDE, 5'd3); tick(); idle(); tick();
      @(negedge clk);
      check("li_a_wr_en", 32'(bus_a.wr_en_RF), 32'd1);
      check("li_a_addr",  32'(bus_a.wr_addr_RF), 32'd3);
      check("li_a_data",  bus_a.Data_In_RF, 32'h000ABCDE);
      tick();
      @(negedge clk);
      check("li_a_count", 32'(bus_a.wb_count), 32'd1);
      check("li_b_data",  bus_b.Data_In_RF, 32'hFFFABCDE);
      tick();

      issue(7'h7F, 20'h80001, 5'd4); tick(); idle(); tick(); tick();
      @(negedge clk);
      check("sx_b_data",   bus_b.Data_In_RF, 32'hFFF80001);
      check("sx_a_hold",   bus_a.Data_In_RF, 32'h00080001);
      tick(); tick();

      // ALU write followed by a NOP that shows the held value
      alu_out = 32'h1234;
      issue(7'h33, 20'h0, 5'd5); tick(); issue(7'h00, 20'h0, 5'd0); tick();
      @(negedge clk);
      check("alu_a_wr_en", 32'(bus_a.wr_en_RF), 32'd1);
      check("alu_a_data",  bus_a.Data_In_RF, 32'h1234);
      idle(); tick();
      alu_out = 32'h5555;
      @(negedge clk);
      check("nop_a_wr_en", 32'(bus_a.wr_en_RF), 32'd0);
      check("nop_a_data",  bus_a.Data_In_RF, 32'h1234);
      tick(); tick(); tick();

      // Writes to x0 and unknown opcodes never commit
      issue(7'h33, 20'h0, 5'd0); tick(); issue(7'h13, 20'h0, 5'd6); tick();
      idle(); tick(); tick(); tick();
      @(negedge clk);
      check("nowr_a_count", 32'(bus_a.wb_count), 32'd3);

      // Hazard window spans LAT cycles; rs2=0 never matches
      rs1 = 5'd7; rs2 = 5'd0;
      issue(7'h7F, 20'h1, 5'd7); tick(); idle();
      @(negedge clk); check("haz_a_c1", 32'(bus_a.hazard), 32'd1);
      tick();
      @(negedge clk); check("haz_a_c2", 32'(bus_a.hazard), 32'd1);
      tick();
      @(negedge clk); check("haz_a_c3", 32'(bus_a.hazard), 32'd0);
      check("haz_a_count", 32'(bus_a.wb_count), 32'd4);
      rs1 = 5'd0;
      tick(); tick();

      // Stall three cycles with an ALU op at write-back
      alu_out = 32'hAAAA;
      issue(7'h33, 20'h0, 5'd9); tick(); idle(); tick();
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("stall_a_wr_en", 32'(bus_a.wr_en_RF), 32'd0);
         check("stall_a_data",  bus_a.Data_In_RF, 32'hAAAA);
         tick();
      end
      stall = 1'b0;
      @(negedge clk);
      check("unstall_a_wr_en", 32'(bus_a.wr_en_RF), 32'd1);
      tick();
      @(negedge clk);
      check("unstall_a_wr_en2", 32'(bus_a.wr_en_RF), 32'd0);
      check("unstall_a_count",  32'(bus_a.wb_count), 32'd5);
      tick(); tick(); tick();

      // Reset mid-flight discards the in-flight load
      issue(7'h7F, 20'h55, 5'd10); tick(); idle();
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_a_wr_en", 32'(bus_a.wr_en_RF), 32'd0);
      check("midrst_a_count", 32'(bus_a.wb_count), 32'd0);
      tick();
      rst_n = 1'b1;
      tick(); tick(); tick(); tick();
      @(negedge clk);
      check("postrst_a_count", 32'(bus_a.wb_count), 32'd0);
      check("postrst_b_count", 32'(bus_b.wb_count), 32'd0);

      // Back-to-back writes saturate the narrow counter
      for (int k = 0; k < 10; k++) begin
         issue(7'h7F, 20'(k + 1), 5'd1);
         tick();
      end
      idle();
      tick(); tick(); tick(); tick();
      @(negedge clk);
      check("sat_a_count", 32'(bus_a.wb_count), 32'd10);
      check("sat_b_count", 32'(bus_b.wb_count), 32'd7);
      tick();

      run = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
